// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Newest producer wins: MEM shadows WB, and x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic wr_m,
                                         input logic wr_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding compare for both source operands.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs1_e,
  input  logic [4:0] i_rs2_e,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_regwrite_m,
  input  logic       i_regwrite_w,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b
);

  // Operand select for A and B from the MEM/WB destinations.
  always_comb begin
    o_fwd_a = fwd_sel(i_rs1_e, i_rd_m, i_rd_w, i_regwrite_m, i_regwrite_w);
    o_fwd_b = fwd_sel(i_rs2_e, i_rd_m, i_rd_w, i_regwrite_m, i_regwrite_w);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and
// data-memory wait freeze with timeout to a sticky error state.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             MemRead_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             BranchTaken_E,
  input  logic             MemReq_M,
  input  logic             MemReady_M,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic [WIDTH-1:0] StallCnt,
  output logic             MemErr
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_e           r_state;
  logic [CW-1:0]    r_wait_cnt;
  logic             r_mem_err;
  logic [WIDTH-1:0] r_stall_cnt;
  logic [CW-1:0]    w_wait_inc;
  logic             w_freeze;
  logic             w_lu;
  logic             w_any_stall;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  forward_unit u_fwd (
    .i_rs1_e      (Rs1_E),
    .i_rs2_e      (Rs2_E),
    .i_rd_m       (Rd_M),
    .i_rd_w       (Rd_W),
    .i_regwrite_m (RegWrite_M),
    .i_regwrite_w (RegWrite_W),
    .o_fwd_a      (w_fwd_a),
    .o_fwd_b      (w_fwd_b)
  );

  assign w_wait_inc  = r_wait_cnt + CW'(1);
  assign w_lu        = MemRead_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
  assign w_any_stall = Stall_F | Stall_D | Stall_E | Stall_M;
  assign StallCnt    = r_stall_cnt;
  assign MemErr      = r_mem_err;

  // Freeze decision from the memory FSM state and this cycle's handshake.
  always_comb begin
    w_freeze = 1'b1;
    case (r_state)
      RUN:      w_freeze = MemReq_M && !MemReady_M;
      MEM_WAIT: w_freeze = !MemReady_M;
      ERROR:    w_freeze = 1'b1;
      default:  w_freeze = 1'b1;
    endcase
  end

  // Stall/flush/forward outputs; reset holds every stage bubbled.
  always_comb begin
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Stall_E    = 1'b0;
    Stall_M    = 1'b0;
    Flush_D    = 1'b1;
    Flush_E    = 1'b1;
    Flush_W    = 1'b1;
    ForwardA_E = FWD_RF;
    ForwardB_E = FWD_RF;
    if (!rst_n) begin
      Flush_W = 1'b1;
    end else if (w_freeze) begin
      Stall_F    = 1'b1;
      Stall_D    = 1'b1;
      Stall_E    = 1'b1;
      Stall_M    = 1'b1;
      Flush_D    = 1'b0;
      Flush_E    = 1'b0;
      ForwardA_E = w_fwd_a;
      ForwardB_E = w_fwd_b;
    end else begin
      Stall_F    = w_lu && !BranchTaken_E;
      Stall_D    = w_lu && !BranchTaken_E;
      Flush_D    = BranchTaken_E;
      Flush_E    = BranchTaken_E || w_lu;
      Flush_W    = 1'b0;
      ForwardA_E = w_fwd_a;
      ForwardB_E = w_fwd_b;
    end
  end

  // Memory wait FSM with timeout into the absorbing error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (MemReq_M && !MemReady_M) begin
            r_wait_cnt <= CW'(1);
            if (MEM_TIMEOUT <= 1) begin
              r_state   <= ERROR;
              r_mem_err <= 1'b1;
            end else begin
              r_state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (MemReady_M) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == CW'(MEM_TIMEOUT)) begin
              r_state   <= ERROR;
              r_mem_err <= 1'b1;
            end
          end
        end
        ERROR: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state   <= ERROR;
          r_mem_err <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles with any stage held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_any_stall && (r_stall_cnt != {WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] Rs1_D = 5'd0, Rs2_D = 5'd0, Rs1_E = 5'd0, Rs2_E = 5'd0;
  logic [4:0] Rd_E = 5'd0, Rd_M = 5'd0, Rd_W = 5'd0;
  logic MemRead_E = 1'b0, RegWrite_M = 1'b0, RegWrite_W = 1'b0;
  logic BranchTaken_E = 1'b0, MemReq_M = 1'b0, MemReady_M = 1'b0;
  logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, MemErr;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic [CNT_W-1:0] StallCnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: wait cycles elapsed, error flag, stall count
  int m_wait = 0;
  bit m_err  = 1'b0;
  int m_cnt  = 0;
  bit e_any_stall;

  hazard_ctrl #(.WIDTH(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .MemRead_E(MemRead_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .BranchTaken_E(BranchTaken_E), .MemReq_M(MemReq_M), .MemReady_M(MemReady_M),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallCnt(StallCnt), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int rs, input int rdm, input int rdw,
                                         input bit wm, input bit ww);
    if (wm && rdm != 0 && rdm == rs) return 2'b10;
    if (ww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic settle(input string tag);
    bit lu, frz, st_fd;
    #1;
    lu    = MemRead_E && (int'(Rd_E) != 0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);
    frz   = m_err || (!MemReady_M && (m_wait > 0 || MemReq_M));
    st_fd = frz || (lu && !BranchTaken_E);
    e_any_stall = st_fd;
    check_val({tag, ".StallF"}, 32'(Stall_F), 32'(st_fd));
    check_val({tag, ".StallD"}, 32'(Stall_D), 32'(st_fd));
    check_val({tag, ".StallE"}, 32'(Stall_E), 32'(frz));
    check_val({tag, ".StallM"}, 32'(Stall_M), 32'(frz));
    check_val({tag, ".FlushD"}, 32'(Flush_D), 32'(!frz && BranchTaken_E));
    check_val({tag, ".FlushE"}, 32'(Flush_E), 32'(!frz && (BranchTaken_E || lu)));
    check_val({tag, ".FlushW"}, 32'(Flush_W), 32'(frz));
    check_val({tag, ".FwdA"}, 32'(ForwardA_E),
              32'(ref_fwd(int'(Rs1_E), int'(Rd_M), int'(Rd_W), RegWrite_M, RegWrite_W)));
    check_val({tag, ".FwdB"}, 32'(ForwardB_E),
              32'(ref_fwd(int'(Rs2_E), int'(Rd_M), int'(Rd_W), RegWrite_M, RegWrite_W)));
    check_val({tag, ".Cnt"}, 32'(StallCnt), 32'(m_cnt));
    check_val({tag, ".Err"}, 32'(MemErr), 32'(m_err));
  endtask

  // Clock edge, then advance the model by one cycle.
  task automatic advance();
    @(posedge clk);
    if (e_any_stall && m_cnt < CMAX) m_cnt++;
    if (!m_err) begin
      if (!MemReady_M && (m_wait > 0 || MemReq_M)) begin
        m_wait++;
        if (m_wait >= TO) m_err = 1'b1;
      end else begin
        m_wait = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_val({tag, ".rStallF"}, 32'(Stall_F), 32'd0);
    check_val({tag, ".rStallM"}, 32'(Stall_M), 32'd0);
    check_val({tag, ".rFlushD"}, 32'(Flush_D), 32'd1);
    check_val({tag, ".rFlushE"}, 32'(Flush_E), 32'd1);
    check_val({tag, ".rFlushW"}, 32'(Flush_W), 32'd1);
    check_val({tag, ".rFwdA"}, 32'(ForwardA_E), 32'd0);
    check_val({tag, ".rCnt"}, 32'(StallCnt), 32'd0);
    check_val({tag, ".rErr"}, 32'(MemErr), 32'd0);
    m_wait = 0;
    m_err  = 1'b0;
    m_cnt  = 0;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, ".rCnt2"}, 32'(StallCnt), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
    {MemRead_E, RegWrite_M, RegWrite_W, BranchTaken_E, MemReq_M, MemReady_M} = '0;
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    do_reset("init");

    // forwarding priority and x0
    Rd_M = 5'd5; RegWrite_M = 1'b1; Rd_W = 5'd5; RegWrite_W = 1'b1; Rs1_E = 5'd5;
    settle("fwd_mem"); check_val("fwd_mem_k", 32'(ForwardA_E), 32'h2); advance();
    RegWrite_M = 1'b0;
    settle("fwd_wb"); check_val("fwd_wb_k", 32'(ForwardA_E), 32'h1); advance();
    Rd_M = 5'd0; RegWrite_M = 1'b1; Rd_W = 5'd0; Rs1_E = 5'd0;
    settle("fwd_x0"); check_val("fwd_x0_k", 32'(ForwardA_E), 32'h0); advance();
    clear_inputs();

    // load-use for one cycle
    MemRead_E = 1'b1; Rd_E = 5'd7; Rs2_D = 5'd7;
    settle("lu"); check_val("lu_k", 32'({Stall_F, Stall_D, Flush_E}), 32'h7); advance();
    MemRead_E = 1'b0;
    settle("lu_after"); check_val("lu_cnt_k", 32'(StallCnt), 32'd1); advance();

    // branch overrides load-use
    MemRead_E = 1'b1; BranchTaken_E = 1'b1;
    settle("br_lu"); check_val("br_lu_k", 32'({Flush_D, Flush_E, Stall_F, Stall_D}), 32'hC);
    advance();
    clear_inputs();

    // memory wait of three cycles
    do_reset("pre_wait");
    MemReq_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle("wait"); check_val("wait_k", 32'({Stall_M, Flush_W}), 32'h3); advance();
    end
    MemReady_M = 1'b1;
    settle("ready"); check_val("ready_k", 32'(Stall_F), 32'd0); advance();
    clear_inputs();
    settle("wait_cnt"); check_val("wait_cnt_k", 32'(StallCnt), 32'd3); advance();

    // freeze masks branch until ready
    MemReq_M = 1'b1; BranchTaken_E = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle("fz_br"); check_val("fz_br_k", 32'({Flush_D, Flush_E}), 32'h0); advance();
    end
    MemReady_M = 1'b1;
    settle("fz_rdy"); check_val("fz_rdy_k", 32'({Flush_D, Flush_E}), 32'h3); advance();
    clear_inputs();

    // timeout into error, then saturation and reset
    do_reset("pre_to");
    MemReq_M = 1'b1;
    for (int i = 0; i < TO; i++) begin
      settle("to_wait"); advance();
    end
    MemReq_M = 1'b0;
    settle("to_err"); check_val("to_err_k", 32'(MemErr), 32'd1);
    check_val("to_frz_k", 32'(Stall_M), 32'd1); advance();
    for (int i = 0; i < 20; i++) begin
      settle("err_hold"); advance();
    end
    check_val("sat_k", 32'(StallCnt), 32'(CMAX));
    do_reset("err_rst");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (m_err || $urandom_range(0, 99) == 0) begin
        clear_inputs();
        do_reset("rnd_rst");
      end
      Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      Rd_E  = 5'($urandom_range(0, 3)); Rd_M  = 5'($urandom_range(0, 3));
      Rd_W  = 5'($urandom_range(0, 3));
      MemRead_E     = ($urandom_range(0, 2) == 0);
      RegWrite_M    = ($urandom_range(0, 1) == 0);
      RegWrite_W    = ($urandom_range(0, 1) == 0);
      BranchTaken_E = ($urandom_range(0, 4) == 0);
      MemReq_M      = ($urandom_range(0, 2) == 0);
      MemReady_M    = ($urandom_range(0, 3) != 0);
      settle("rnd");
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Generates stall and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers, and operand-forwarding selects for the EX stage.
- Freezes the pipeline during data-memory wait states through a small FSM with timeout.
- Sits beside the datapath; the ID/EX register consumes its flush output as its existing flush input.

Parameters:
- WIDTH, 32, width of the performance stall counter.
- MEM_TIMEOUT, 64, maximum consecutive memory wait cycles before the error state.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Rs1_D  in  5  source reg 1 of instruction in ID
- Rs2_D  in  5  source reg 2 of instruction in ID
- Rs1_E  in  5  source reg 1 in EX
- Rs2_E  in  5  source reg 2 in EX
- Rd_E  in  5  destination in EX
- Rd_M  in  5  destination in MEM
- Rd_W  in  5  destination in WB
- MemRead_E  in  1  instruction in EX is a load
- RegWrite_M  in  1  MEM instruction writes the register file
- RegWrite_W  in  1  WB instruction writes the register file
- BranchTaken_E  in  1  EX resolved a taken branch or jump (PC redirect)
- MemReq_M  in  1  MEM stage issues a data-memory access
- MemReady_M  in  1  data memory completes the access this cycle
- Stall_F  out  1  hold PC
- Stall_D  out  1  hold IF/ID
- Stall_E  out  1  hold ID/EX
- Stall_M  out  1  hold EX/MEM
- Flush_D  out  1  bubble IF/ID
- Flush_E  out  1  bubble ID/EX (drives its flush input)
- Flush_W  out  1  bubble MEM/WB
- ForwardA_E  out  2  EX operand A select: 00 regfile, 10 from MEM, 01 from WB
- ForwardB_E  out  2  EX operand B select, same encoding
- StallCnt  out  WIDTH  saturating count of frozen cycles
- MemErr  out  1  sticky memory timeout flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - state RUN, wait counter 0, StallCnt 0, MemErr 0.
  - Combinational outputs while in reset: Stall_* 0, Flush_D 1, Flush_E 1, Flush_W 1, Forward* 00.
- Forwarding (combinational, every cycle):
  - A selects 10 if RegWrite_M and Rd_M != 0 and Rd_M == Rs1_E.
  - Otherwise A selects 01 if RegWrite_W and Rd_W != 0 and Rd_W == Rs1_E.
  - Otherwise A selects 00. B uses the same rules with Rs2_E.
  - MEM has priority over WB. x0 is never forwarded.
- Load-use (combinational):
  - lu = MemRead_E and Rd_E != 0 and (Rd_E == Rs1_D or Rd_E == Rs2_D).
  - lu gives Stall_F = 1, Stall_D = 1, Flush_E = 1. Latency is one bubble.
- Branch redirect: BranchTaken_E gives Flush_D = 1 and Flush_E = 1. It suppresses the lu stall (Stall_F and Stall_D stay 0).
- FSM states RUN, MEM_WAIT, ERROR:
  - freeze = (state RUN and MemReq_M and not MemReady_M) or state MEM_WAIT and not MemReady_M, or state ERROR.
  - freeze gives Stall_F, Stall_D, Stall_E, Stall_M = 1 and Flush_W = 1.
  - freeze forces Flush_D = 0 and Flush_E = 0. Branch and lu effects are deferred; their inputs hold because the stages are frozen.
  - RUN to MEM_WAIT when MemReq_M and not MemReady_M; the wait counter loads 1.
  - MEM_WAIT to RUN on MemReady_M. Stalls deassert in that same cycle.
  - MEM_WAIT to ERROR when the wait counter reaches MEM_TIMEOUT without MemReady_M. This sets MemErr.
  - In MEM_WAIT the wait counter increments each cycle.
  - ERROR is absorbing: full freeze, and only rst_n exits.
- MemReq_M with MemReady_M in the same cycle in RUN gives zero stall.
- StallCnt increments on every cycle where any Stall_* = 1, saturating at all ones. Reset mid-wait clears everything immediately.
- Priority: freeze > BranchTaken_E > lu.

Decomposition:
- Package hazard_pkg holds:
  - state enum (RUN, MEM_WAIT, ERROR);
  - forward-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One sub-module, forward_unit, is natural: the pure combinational forwarding compare, instantiated once and covering both operands.

Test Plan:
- Forwarding:
  - Rd_M = 5, RegWrite_M = 1, Rd_W = 5, RegWrite_W = 1, Rs1_E = 5 -> ForwardA_E = 10.
  - Same with RegWrite_M = 0 -> 01.
  - Rd_M = 0, Rs1_E = 0 -> 00.
- Load-use: MemRead_E = 1, Rd_E = 7, Rs2_D = 7 -> Stall_F = Stall_D = Flush_E = 1 for exactly one cycle. Next cycle (MemRead_E = 0) all 0. StallCnt = 1.
- Branch vs load-use: BranchTaken_E = 1 with lu conditions true -> Flush_D = Flush_E = 1, Stall_F = Stall_D = 0.
- Memory wait:
  - MemReq_M = 1, MemReady_M low for 3 cycles then high -> all Stall_* = 1 and Flush_W = 1 for 3 cycles, then 0 in the ready cycle.
  - State RUN -> MEM_WAIT -> RUN. StallCnt = 3.
- Timeout: MEM_TIMEOUT = 4, MemReady_M never asserted -> ERROR after 4 wait cycles, MemErr = 1, freeze persists.
  - Assert rst_n = 0 mid-ERROR -> MemErr = 0, StallCnt = 0, Flush_D/E/W = 1 while low.
- Freeze masks branch: MEM_WAIT with BranchTaken_E = 1 -> Flush_D = Flush_E = 0. In the MemReady_M cycle -> Flush_D = Flush_E = 1.
